target_ibi_ctrl: RTL
====================

// Module: target_ibi_ctrl
// PURPOSE
//  Target-mode In-Band Interrupt request sequencer, downstream of the address/config extraction block.
//  Consumes its IBI enable, retry count and effective IBI address; waits for bus-available or controller START,
//  asks the bus TX stage to drive {addr,RnW=1}, handles ACK/NACK/arbitration loss with retries.
//  Reports one status pulse per request back to the TTI side.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles in WAIT_RES before aborting with TIMEOUT; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk_i                  in   1  clock
//  rst_i                  in   1  reset, asynchronous, active-high
//  ibi_enable_i           in   1  IBI enable from config
//  ibi_retry_num_i        in   3  retries after first attempt
//  target_ibi_addr_i      in   7  effective IBI address
//  target_ibi_addr_valid_i in  1  address valid
//  bus_available_i        in   1  level, bus-available timer expired
//  bus_start_det_i        in   1  pulse, controller START seen
//  ibi_req_valid_i        in   1  TTI IBI request
//  ibi_req_mdb_i          in   8  mandatory data byte
//  ibi_req_ready_o        out  1  request accepted when valid&ready
//  tx_req_o               out  1  header request to bus TX stage
//  tx_hdr_o               out  8  {addr,1'b1}
//  tx_ack_i               in   1  TX stage took request
//  tx_res_valid_i         in   1  header result pulse
//  tx_res_i               in   2  00 ACK, 01 NACK, 10 ARB_LOST, 11 reserved (treated as NACK)
//  tx_mdb_valid_o/tx_mdb_o out 1/8 MDB to TX stage (TARGET_IBI_MDB_EN only; else tied 0)
//  tx_mdb_ready_i         in   1  MDB accepted
//  ibi_status_valid_o     out  1  one-cycle status pulse
//  ibi_status_o           out  3  0 OK, 1 RETRY_EXHAUSTED, 2 TIMEOUT, 3 DISABLED
//  ibi_retries_o          out  3  retries consumed
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs 0; ibi_req_ready_o = (state==IDLE), so 1 in reset.
//  IDLE: on valid&ready latch addr, mdb, retry_num; retry_cnt<=0. If !ibi_enable_i or !addr_valid -> REPORT(DISABLED), else WAIT_AVAIL.
//  WAIT_AVAIL: bus_available_i | bus_start_det_i -> REQ next cycle. ibi_enable_i low -> REPORT(DISABLED); enable wins over simultaneous available.
//  REQ: tx_req_o=1, tx_hdr_o stable until tx_ack_i; then WAIT_RES, watchdog cleared. Enable drop ignored from REQ onward.
//  WAIT_RES: watchdog increments each cycle; tx_res_valid_i wins over same-cycle expiry.
//   ACK -> SEND_MDB (macro) or REPORT(OK).
//   NACK/ARB_LOST/11: retry_cnt < latched retry_num -> retry_cnt+1, WAIT_AVAIL; else REPORT(RETRY_EXHAUSTED).
//   watchdog == TIMEOUT_CYCLES-1 without result -> REPORT(TIMEOUT).
//  SEND_MDB: tx_mdb_valid_o=1 until tx_mdb_ready_i -> REPORT(OK).
//  REPORT: ibi_status_valid_o=1 exactly one cycle with status and retry_cnt; then IDLE. Pulse, no backpressure.
//  Latency: accept to tx_req_o = 2 cycles if bus_available_i already high. Config changes mid-request ignored except enable in WAIT_AVAIL.
//  Reset mid-request: immediate IDLE, no status pulse, tx_req_o drops asynchronously.
// CONFIGURATION
//  TARGET_IBI_MDB_EN defined: BCR[2]=1 mode, SEND_MDB state exists, MDB sent after ACK.
//  Undefined: no SEND_MDB; ACK -> REPORT(OK); tx_mdb_valid_o/tx_mdb_o tied 0; ibi_req_mdb_i unused.
// STRUCTURE
//  Package i3c_pkg: ibi_status_e (3b), tx_res_e (2b), ibi_ctrl_state_e.
//  One sub-module: ibi_timeout_cnt (clear/enable counter, parameterised limit, expire flag).
// TESTING
//  enable=1, addr=0x2A valid, bus_available=1 -> tx_hdr_o=0x55 at 2 cycles; ACK -> status OK, retries 0.
//  retry_num=2, results NACK,ARB_LOST,NACK -> 3 tx_req_o; status RETRY_EXHAUSTED, retries 2.
//  retry_num=0, NACK -> one attempt; status RETRY_EXHAUSTED, retries 0.
//  enable=0 at accept -> status DISABLED 1 cycle later, no tx_req_o; enable dropped in WAIT_AVAIL -> DISABLED.
//  TIMEOUT_CYCLES=16, no tx_res_valid_i after ack -> status TIMEOUT 16 cycles after ack; result on expiry cycle wins.
//  MDB_EN, mdb=0xA5, ACK, ready after 3 cycles -> tx_mdb_o=0xA5 held; OK after ready; rst_i mid-WAIT_RES -> IDLE, no status.

Source files
------------

// File: rtl/i3c_pkg.sv
// Shared types for the target-mode IBI sequencer: status codes, TX result codes, FSM states.
package i3c_pkg;

  typedef enum logic [2:0] {
    IBI_OK              = 3'd0,
    IBI_RETRY_EXHAUSTED = 3'd1,
    IBI_TIMEOUT         = 3'd2,
    IBI_DISABLED        = 3'd3
  } ibi_status_e;

  typedef enum logic [1:0] {
    TX_ACK      = 2'b00,
    TX_NACK     = 2'b01,
    TX_ARB_LOST = 2'b10,
    TX_RSVD     = 2'b11
  } tx_res_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_AVAIL = 3'd1,
    ST_REQ        = 3'd2,
    ST_WAIT_RES   = 3'd3,
    ST_SEND_MDB   = 3'd4,
    ST_REPORT     = 3'd5
  } ibi_ctrl_state_e;

  // IBI header: 7-bit address followed by RnW=1.
  function automatic logic [7:0] ibi_hdr(input logic [6:0] addr);
    return {addr, 1'b1};
  endfunction

endpackage

// File: rtl/ibi_timeout_cnt.sv
// Watchdog counter: cleared while idle, counts while enabled, flags the LIMIT-th cycle.
module ibi_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= {W{1'b0}};
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/target_ibi_ctrl.sv
// Target-mode IBI request sequencer: header request, ACK/NACK/arbitration retries, watchdog, status pulse.
// Define TARGET_IBI_MDB_EN to send the mandatory data byte after the header is ACKed.
module target_ibi_ctrl
  import i3c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ibi_enable_i,
  input  logic [2:0] ibi_retry_num_i,
  input  logic [6:0] target_ibi_addr_i,
  input  logic       target_ibi_addr_valid_i,
  input  logic       bus_available_i,
  input  logic       bus_start_det_i,
  input  logic       ibi_req_valid_i,
  input  logic [7:0] ibi_req_mdb_i,
  output logic       ibi_req_ready_o,
  output logic       tx_req_o,
  output logic [7:0] tx_hdr_o,
  input  logic       tx_ack_i,
  input  logic       tx_res_valid_i,
  input  logic [1:0] tx_res_i,
  output logic       tx_mdb_valid_o,
  output logic [7:0] tx_mdb_o,
  input  logic       tx_mdb_ready_i,
  output logic       ibi_status_valid_o,
  output logic [2:0] ibi_status_o,
  output logic [2:0] ibi_retries_o
);

  ibi_ctrl_state_e state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [2:0]  retry_num_q, retry_num_d;
  logic [2:0]  retry_cnt_q, retry_cnt_d;
  logic        tx_req_q, tx_req_d;
  logic [7:0]  tx_hdr_q, tx_hdr_d;
  logic        status_valid_q, status_valid_d;
  ibi_status_e status_q, status_d;
  logic [2:0]  retries_q, retries_d;
  logic        wd_expire;

  ibi_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state_q != ST_WAIT_RES),
    .en_i     (state_q == ST_WAIT_RES),
    .expire_o (wd_expire)
  );

`ifdef TARGET_IBI_MDB_EN
  logic [7:0] mdb_q, mdb_d;
  logic       mdb_valid_q, mdb_valid_d;
  assign tx_mdb_valid_o = mdb_valid_q;
  assign tx_mdb_o       = mdb_q;
`else
  logic mdb_unused;
  assign mdb_unused     = ^{ibi_req_mdb_i, tx_mdb_ready_i};
  assign tx_mdb_valid_o = 1'b0;
  assign tx_mdb_o       = 8'h00;
`endif

  assign ibi_req_ready_o    = (state_q == ST_IDLE);
  assign tx_req_o           = tx_req_q;
  assign tx_hdr_o           = tx_hdr_q;
  assign ibi_status_valid_o = status_valid_q;
  assign ibi_status_o       = status_q;
  assign ibi_retries_o      = retries_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    retry_num_d    = retry_num_q;
    retry_cnt_d    = retry_cnt_q;
    tx_req_d       = tx_req_q;
    tx_hdr_d       = tx_hdr_q;
    status_valid_d = 1'b0;
    status_d       = status_q;
    retries_d      = retries_q;
`ifdef TARGET_IBI_MDB_EN
    mdb_d          = mdb_q;
    mdb_valid_d    = mdb_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ibi_req_valid_i) begin
          addr_d      = target_ibi_addr_i;
          retry_num_d = ibi_retry_num_i;
          retry_cnt_d = 3'd0;
`ifdef TARGET_IBI_MDB_EN
          mdb_d       = ibi_req_mdb_i;
`endif
          if (!ibi_enable_i || !target_ibi_addr_valid_i) begin
            state_d = ST_REPORT; status_valid_d = 1'b1; status_d = IBI_DISABLED; retries_d = 3'd0;
          end else begin
            state_d = ST_WAIT_AVAIL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_AVAIL: begin
        // Losing enable takes priority over a bus opportunity in the same cycle.
        if (!ibi_enable_i) begin
          state_d = ST_REPORT; status_valid_d = 1'b1; status_d = IBI_DISABLED; retries_d = retry_cnt_q;
        end else if (bus_available_i || bus_start_det_i) begin
          state_d  = ST_REQ;
          tx_req_d = 1'b1;
          tx_hdr_d = ibi_hdr(addr_q);
        end else begin
          state_d = ST_WAIT_AVAIL;
        end
      end
      ST_REQ: begin
        if (tx_ack_i) begin
          state_d  = ST_WAIT_RES;
          tx_req_d = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT_RES: begin
        if (tx_res_valid_i) begin
          case (tx_res_e'(tx_res_i))
            TX_ACK: begin
`ifdef TARGET_IBI_MDB_EN
              state_d = ST_SEND_MDB; mdb_valid_d = 1'b1;
`else
              state_d = ST_REPORT; status_valid_d = 1'b1; status_d = IBI_OK; retries_d = retry_cnt_q;
`endif
            end
            default: begin
              if (retry_cnt_q < retry_num_q) begin
                state_d     = ST_WAIT_AVAIL;
                retry_cnt_d = retry_cnt_q + 3'd1;
              end else begin
                state_d = ST_REPORT; status_valid_d = 1'b1; status_d = IBI_RETRY_EXHAUSTED; retries_d = retry_cnt_q;
              end
            end
          endcase
        end else if (wd_expire) begin
          state_d = ST_REPORT; status_valid_d = 1'b1; status_d = IBI_TIMEOUT; retries_d = retry_cnt_q;
        end else begin
          state_d = ST_WAIT_RES;
        end
      end
      ST_SEND_MDB: begin
`ifdef TARGET_IBI_MDB_EN
        if (tx_mdb_ready_i) begin
          mdb_valid_d = 1'b0;
          state_d = ST_REPORT; status_valid_d = 1'b1; status_d = IBI_OK; retries_d = retry_cnt_q;
        end else begin
          state_d = ST_SEND_MDB;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      addr_q         <= 7'd0;
      retry_num_q    <= 3'd0;
      retry_cnt_q    <= 3'd0;
      tx_req_q       <= 1'b0;
      tx_hdr_q       <= 8'h00;
      status_valid_q <= 1'b0;
      status_q       <= IBI_OK;
      retries_q      <= 3'd0;
`ifdef TARGET_IBI_MDB_EN
      mdb_q          <= 8'h00;
      mdb_valid_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      retry_num_q    <= retry_num_d;
      retry_cnt_q    <= retry_cnt_d;
      tx_req_q       <= tx_req_d;
      tx_hdr_q       <= tx_hdr_d;
      status_valid_q <= status_valid_d;
      status_q       <= status_d;
      retries_q      <= retries_d;
`ifdef TARGET_IBI_MDB_EN
      mdb_q          <= mdb_d;
      mdb_valid_q    <= mdb_valid_d;
`endif
    end
  end

endmodule
